dclock_key_frontend: RTL

//  Button front end for the digital clock. Debounces five raw active-low push buttons and holds the mode state.

---
 rtl/dclock_key_frontend_pkg.sv | 48 ++++
 rtl/dclock_key_frontend_if.sv | 28 ++
 rtl/dclock_key_frontend_debounce.sv | 64 ++++++
 rtl/dclock_key_frontend.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dclock_key_frontend_pkg.sv
// Shared types and constants for the digital-clock button front end.
//  - mode / edit-field encodings and their advance order
//  - repeat FSM state type
//  - button bit positions inside btn_n
package dclock_key_pkg;

  localparam int NUM_BTN   = 5;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;  // must stay BTN_UP+1: repeat FSMs index by offset
  localparam int BTN_MODE  = 2;
  localparam int BTN_SEL   = 3;
  localparam int BTN_ALMEN = 4;

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'd0,
    MODE_ALARM     = 2'd1,
    MODE_STOPWATCH = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    EDIT_NONE = 2'd0,
    EDIT_MIN  = 2'd1,
    EDIT_HOUR = 2'd2
  } edit_e;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_HOLD   = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_CLOCK: return MODE_ALARM;
      MODE_ALARM: return MODE_STOPWATCH;
      default:    return MODE_CLOCK;
    endcase
  endfunction

  function automatic edit_e next_edit(input edit_e e);
    case (e)
      EDIT_NONE: return EDIT_MIN;
      EDIT_MIN:  return EDIT_HOUR;
      default:   return EDIT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dclock_key_frontend_if.sv
// Button/control bundle between the board, the key front end and the clock logic.
//  btn_n      raw active-low buttons [up, down, mode, sel, alarm-enable]
//  key1/key2  active-low one-cycle key pulses
//  alarm, stopwatch, remin, rehour, alarm_en  mode / edit-field levels
// master: the key front end (reads buttons, drives controls)
// slave : the board + clock logic side
interface dclock_key_if;
  import dclock_key_pkg::*;

  logic [NUM_BTN-1:0] btn_n;
  logic               key1;
  logic               key2;
  logic               alarm;
  logic               stopwatch;
  logic               remin;
  logic               rehour;
  logic               alarm_en;

  modport master (
    input  btn_n,
    output key1, key2, alarm, stopwatch, remin, rehour, alarm_en
  );

  modport slave (
    output btn_n,
    input  key1, key2, alarm, stopwatch, remin, rehour, alarm_en
  );
endinterface

// File: rtl/dclock_key_frontend_debounce.sv
// key_debounce: one raw active-low button -> debounced level + press strobe.
//  clkkey     sampling clock
//  rst_N      async active-low reset
//  raw_n      raw button, active-low, asynchronous
//  pressed    debounced level, 1 = pressed
//  press_evt  one-cycle strobe on released->pressed
// A level change is accepted after DEB_CYCLES consecutive synchronized samples
// disagreeing with the current debounced level; any agreeing sample restarts it.
module key_debounce
  import dclock_key_pkg::*;
#(
  parameter int DEB_CYCLES = 3
) (
  input  logic clkkey,
  input  logic rst_N,
  input  logic raw_n,
  output logic pressed,
  output logic press_evt
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          pressed_q, pressed_d;
  logic          evt_q, evt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d   = raw_n;
    sync2_d   = sync1_q;
    pressed_d = pressed_q;
    evt_d     = 1'b0;
    cnt_d     = '0;
    if (~sync2_q != pressed_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        pressed_d = ~pressed_q;
        evt_d     = ~pressed_q;  // strobe only on the press direction
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clkkey or negedge rst_N) begin
    if (!rst_N) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      pressed_q <= 1'b0;
      evt_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pressed_q <= pressed_d;
      evt_q     <= evt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pressed   = pressed_q;
  assign press_evt = evt_q;

endmodule

// File: rtl/dclock_key_frontend.sv
// dclock_key_frontend: debounces the five clock buttons and holds mode state.
//  clkkey  key-sampling clock (shared with the clock logic)
//  rst_N   async active-low reset
//  kif     dclock_key_if.master: btn_n in; key1, key2, alarm, stopwatch,
//          remin, rehour, alarm_en out (all straight from flops)
// up/down each drive a repeat FSM (IDLE/HOLD/REPEAT) producing active-low key
// pulses; auto-repeat only while an edit field is selected outside stopwatch.
module dclock_key_frontend
  import dclock_key_pkg::*;
#(
  parameter int DEB_CYCLES    = 3,
  parameter int HOLD_CYCLES   = 10,
  parameter int REPEAT_CYCLES = 2
) (
  input logic          clkkey,
  input logic          rst_N,
  dclock_key_if.master kif
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  // ---------------- debounce, one instance per button
  logic [NUM_BTN-1:0] btn_n, pressed, press_evt;
  assign btn_n = kif.btn_n;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb [NUM_BTN-1:0] (
    .clkkey    (clkkey),
    .rst_N     (rst_N),
    .raw_n     (btn_n),
    .pressed   (pressed),
    .press_evt (press_evt)
  );

  // mode/sel/alarm-enable act on their strobes only; their levels are spare
  logic unused_levels;
  assign unused_levels = &{1'b0, pressed[BTN_ALMEN:BTN_MODE]};

  // ---------------- mode / edit / alarm enable
  mode_e mode_q, mode_d;
  edit_e edit_q, edit_d;
  logic  alarm_q, alarm_d, stopwatch_q, stopwatch_d;
  logic  remin_q, remin_d, rehour_q, rehour_d, almen_q, almen_d;

  always_comb begin
    mode_d = mode_q;
    edit_d = edit_q;
    if (press_evt[BTN_MODE]) begin
      mode_d = next_mode(mode_q);
      edit_d = EDIT_NONE;            // mode wins; a same-edge sel is dropped
    end else if (press_evt[BTN_SEL] && mode_q != MODE_STOPWATCH) begin
      edit_d = next_edit(edit_q);
    end
    almen_d     = almen_q ^ press_evt[BTN_ALMEN];
    alarm_d     = (mode_d == MODE_ALARM);
    stopwatch_d = (mode_d == MODE_STOPWATCH);
    remin_d     = (edit_d == EDIT_MIN);
    rehour_d    = (edit_d == EDIT_HOUR);
  end

  always_ff @(posedge clkkey or negedge rst_N) begin
    if (!rst_N) begin
      mode_q      <= MODE_CLOCK;
      edit_q      <= EDIT_NONE;
      alarm_q     <= 1'b0;
      stopwatch_q <= 1'b0;
      remin_q     <= 1'b0;
      rehour_q    <= 1'b0;
      almen_q     <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      edit_q      <= edit_d;
      alarm_q     <= alarm_d;
      stopwatch_q <= stopwatch_d;
      remin_q     <= remin_d;
      rehour_q    <= rehour_d;
      almen_q     <= almen_d;
    end
  end

  // ---------------- repeat FSMs: k=0 up->key1, k=1 down->key2
  logic rep_en, both_held;
  logic [1:0] key_n;
  assign rep_en    = (edit_q != EDIT_NONE) && (mode_q != MODE_STOPWATCH);
  assign both_held = pressed[BTN_UP] & pressed[BTN_DOWN];

  for (genvar k = 0; k < 2; k++) begin : g_rpt
    rpt_state_e       st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_q, key_d, pulse;
    logic             held, evt, hold_done, rpt_done;

    assign held      = pressed[BTN_UP + k];
    assign evt       = press_evt[BTN_UP + k];
    assign hold_done = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
    assign rpt_done  = (cnt_q == CNT_W'(REPEAT_CYCLES - 1));

    always_ff @(posedge clkkey or negedge rst_N) begin
      if (!rst_N) begin
        st_q  <= RPT_IDLE;
        cnt_q <= '0;
        key_q <= 1'b1;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        key_q <= key_d;
      end
    end

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      if (both_held) begin
        // parked in IDLE: only a fresh press event can start it again
        st_d  = RPT_IDLE;
        cnt_d = '0;
      end else begin
        case (st_q)
          RPT_IDLE: begin
            cnt_d = '0;
            if (evt) st_d = RPT_HOLD;
          end
          RPT_HOLD: begin
            if (!held) begin
              st_d  = RPT_IDLE;
              cnt_d = '0;
            end else if (hold_done) begin
              // without repeat enable, sit here until release
              if (rep_en) begin
                st_d  = RPT_REPEAT;
                cnt_d = '0;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          RPT_REPEAT: begin
            if (!held) begin
              st_d  = RPT_IDLE;
              cnt_d = '0;
            end else if (rpt_done) begin
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            st_d  = RPT_IDLE;
            cnt_d = '0;
          end
        endcase
      end
    end

    always_comb begin
      pulse = 1'b0;
      if (!both_held) begin
        case (st_q)
          RPT_IDLE:   pulse = evt;
          RPT_HOLD:   pulse = held && hold_done && rep_en;
          RPT_REPEAT: pulse = held && rpt_done;
          default:    pulse = 1'b0;
        endcase
      end
      key_d = ~pulse;
    end

    assign key_n[k] = key_q;
  end

  assign kif.key1      = key_n[0];
  assign kif.key2      = key_n[1];
  assign kif.alarm     = alarm_q;
  assign kif.stopwatch = stopwatch_q;
  assign kif.remin     = remin_q;
  assign kif.rehour    = rehour_q;
  assign kif.alarm_en  = almen_q;

endmodule
